// File: rtl/apb_clk_cfg_bridge.sv
// APB slave bridging CPU register accesses onto the clock generator's req/ack config
// handshakes for the soc, per and cluster domains, plus a local lock/timeout status register.
module apb_clk_cfg_bridge #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      soc_cfg_req_o,
  input  logic                      soc_cfg_ack_i,
  output logic [1:0]                soc_cfg_add_o,
  output logic [31:0]               soc_cfg_data_o,
  output logic                      soc_cfg_wrn_o,
  input  logic [31:0]               soc_cfg_r_data_i,
  input  logic                      soc_cfg_lock_i,
  output logic                      per_cfg_req_o,
  input  logic                      per_cfg_ack_i,
  output logic [1:0]                per_cfg_add_o,
  output logic [31:0]               per_cfg_data_o,
  output logic                      per_cfg_wrn_o,
  input  logic [31:0]               per_cfg_r_data_i,
  input  logic                      per_cfg_lock_i,
  output logic                      cluster_cfg_req_o,
  input  logic                      cluster_cfg_ack_i,
  output logic [1:0]                cluster_cfg_add_o,
  output logic [31:0]               cluster_cfg_data_o,
  output logic                      cluster_cfg_wrn_o,
  input  logic [31:0]               cluster_cfg_r_data_i,
  input  logic                      cluster_cfg_lock_i
);

  localparam int          CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0] TMO_DATA = 32'hDEAD_C1C0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_dom;
  logic [1:0]        r_add;
  logic [31:0]       r_wdata;
  logic              r_wr;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_prdata;
  logic [2:0]        r_tmo;

  logic              w_is_stat, w_dom_acc, w_stat_acc;
  logic              w_sel_ack, w_tmo_hit, w_tmo_event;
  logic [31:0]       w_sel_rdata, w_status;
  logic [2:0]        w_dom_oh, w_tmo_set, w_tmo_clr;
  logic              w_unused;

  assign w_is_stat  = (PADDR[5:4] == 2'b11);
  assign w_dom_acc  = (r_state == S_IDLE) && PSEL && PENABLE && !w_is_stat;
  assign w_stat_acc = (r_state == S_IDLE) && PSEL && PENABLE && w_is_stat;
  assign w_status   = {25'b0, r_tmo, 1'b0, cluster_cfg_lock_i, per_cfg_lock_i, soc_cfg_lock_i};
  assign w_tmo_hit  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_unused   = &{1'b0, PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};

  always_comb begin
    w_sel_ack   = 1'b0;
    w_sel_rdata = 32'b0;
    w_dom_oh    = 3'b000;
    case (r_dom)
      2'd0: begin w_sel_ack = soc_cfg_ack_i;     w_sel_rdata = soc_cfg_r_data_i;     w_dom_oh = 3'b001; end
      2'd1: begin w_sel_ack = per_cfg_ack_i;     w_sel_rdata = per_cfg_r_data_i;     w_dom_oh = 3'b010; end
      2'd2: begin w_sel_ack = cluster_cfg_ack_i; w_sel_rdata = cluster_cfg_r_data_i; w_dom_oh = 3'b100; end
      default: ;
    endcase
  end

  // Timeout fires only when the awaited ack edge has not arrived in the last allowed cycle.
  assign w_tmo_event = w_tmo_hit &&
                       (((r_state == S_REQ) && !w_sel_ack) || ((r_state == S_RELEASE) && w_sel_ack));
  assign w_tmo_set   = w_tmo_event ? w_dom_oh : 3'b000;
  assign w_tmo_clr   = (w_stat_acc && PWRITE) ? PWDATA[6:4] : 3'b000;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_dom_acc) w_next = S_REQ;
      S_REQ:     if (w_sel_ack) w_next = S_RELEASE;
                 else if (w_tmo_hit) w_next = S_RESP;
      S_RELEASE: if (!w_sel_ack || w_tmo_hit) w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_dom    <= 2'b0;
      r_add    <= 2'b0;
      r_wdata  <= 32'b0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_prdata <= 32'b0;
      r_tmo    <= 3'b0;
    end else begin
      if (w_dom_acc) begin
        r_dom   <= PADDR[5:4];
        r_add   <= PADDR[3:2];
        r_wdata <= PWDATA;
        r_wr    <= PWRITE;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end else if ((r_state == S_REQ) || (r_state == S_RELEASE)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_tmo_event) r_err <= 1'b1;
      // A late-arriving timeout on a read overrides any data captured earlier in the handshake.
      if (w_tmo_event && !r_wr)
        r_prdata <= TMO_DATA;
      else if ((r_state == S_REQ) && w_sel_ack && !r_wr)
        r_prdata <= w_sel_rdata;
      else if (w_stat_acc && !PWRITE)
        r_prdata <= w_status;
      r_tmo <= (r_tmo & ~w_tmo_clr) | w_tmo_set;
    end
  end

  always_comb begin
    logic [2:0] w_req_oh, w_act_oh;
    w_req_oh = (r_state == S_REQ)  ? w_dom_oh : 3'b000;
    w_act_oh = (r_state != S_IDLE) ? w_dom_oh : 3'b000;

    PREADY  = (r_state == S_RESP) || w_stat_acc;
    PSLVERR = (r_state == S_RESP) && r_err;
    PRDATA  = (w_stat_acc && !PWRITE) ? w_status : r_prdata;

    soc_cfg_req_o      = w_req_oh[0];
    soc_cfg_add_o      = w_act_oh[0] ? r_add   : 2'b0;
    soc_cfg_data_o     = w_act_oh[0] ? r_wdata : 32'b0;
    soc_cfg_wrn_o      = w_act_oh[0] && r_wr;
    per_cfg_req_o      = w_req_oh[1];
    per_cfg_add_o      = w_act_oh[1] ? r_add   : 2'b0;
    per_cfg_data_o     = w_act_oh[1] ? r_wdata : 32'b0;
    per_cfg_wrn_o      = w_act_oh[1] && r_wr;
    cluster_cfg_req_o  = w_req_oh[2];
    cluster_cfg_add_o  = w_act_oh[2] ? r_add   : 2'b0;
    cluster_cfg_data_o = w_act_oh[2] ? r_wdata : 32'b0;
    cluster_cfg_wrn_o  = w_act_oh[2] && r_wr;
  end

endmodule

// File: tb/tb_apb_clk_cfg_bridge.sv
// Directed bench for apb_clk_cfg_bridge: table of APB vectors plus hand-written
// sequences for timeouts, non-selected acks, W1C status and mid-transaction reset.
module tb_apb_clk_cfg_bridge;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [2:0]  req, wrn, ack, lock = 3'b000;
  logic [1:0]  add [3];
  logic [31:0] cdata [3];
  logic [31:0] rdat [3];

  int mode [3];
  int dly  [3];
  int tcnt [3];
  logic [2:0] seen;

  int ntests = 0, nfail = 0;
  int mon_clu_cnt = 0, mon_bad = 0;
  logic [1:0]  mon_clu_add;
  logic [31:0] mon_clu_data;
  logic        mon_clu_wrn;

  always #5 clk = ~clk;

  apb_clk_cfg_bridge #(.TIMEOUT_CYCLES(TMO), .APB_ADDR_WIDTH(12)) dut (
    .clk_i(clk), .rstn_i(rstn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel), .PENABLE(penable), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .soc_cfg_req_o(req[0]), .soc_cfg_ack_i(ack[0]), .soc_cfg_add_o(add[0]),
    .soc_cfg_data_o(cdata[0]), .soc_cfg_wrn_o(wrn[0]), .soc_cfg_r_data_i(rdat[0]),
    .soc_cfg_lock_i(lock[0]),
    .per_cfg_req_o(req[1]), .per_cfg_ack_i(ack[1]), .per_cfg_add_o(add[1]),
    .per_cfg_data_o(cdata[1]), .per_cfg_wrn_o(wrn[1]), .per_cfg_r_data_i(rdat[1]),
    .per_cfg_lock_i(lock[1]),
    .cluster_cfg_req_o(req[2]), .cluster_cfg_ack_i(ack[2]), .cluster_cfg_add_o(add[2]),
    .cluster_cfg_data_o(cdata[2]), .cluster_cfg_wrn_o(wrn[2]), .cluster_cfg_r_data_i(rdat[2]),
    .cluster_cfg_lock_i(lock[2])
  );

  assign rdat[0] = 32'h5A5A_0000;
  assign rdat[1] = 32'h0002_0003;
  assign rdat[2] = 32'hC0FF_EE00;

  // Clock generator model: mode 0 = ack follows req after dly cycles, 1 = stuck 0,
  // 2 = stuck 1 once the first req has been seen.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      tcnt[d] <= req[d] ? tcnt[d] + 1 : 0;
      seen[d] <= (mode[d] == 2) && (seen[d] || req[d]);
    end
  end

  always_comb begin
    ack = 3'b000;
    for (int d = 0; d < 3; d++) begin
      case (mode[d])
        0: ack[d] = req[d] && (tcnt[d] >= dly[d]);
        2: ack[d] = req[d] || seen[d];
        default: ack[d] = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (req[2]) begin
      mon_clu_cnt  <= mon_clu_cnt + 1;
      mon_clu_add  <= add[2];
      mon_clu_data <= cdata[2];
      mon_clu_wrn  <= wrn[2];
      if (req[0] || req[1] || add[0] != 0 || add[1] != 0 || cdata[0] != 0 || cdata[1] != 0 ||
          wrn[0] || wrn[1])
        mon_bad <= mon_bad + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb(input logic [11:0] a, input logic [31:0] wd, input logic wr,
                     output logic [31:0] rd, output logic err, output int waits);
    bit done = 0;
    @(posedge clk); #1;
    paddr = a; pwdata = wd; pwrite = wr; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; rd = 'x; err = 1'bx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pready) begin
        rd = prdata; err = pslverr; done = 1;
        break;
      end
      waits++;
    end
    if (!done) begin
      ntests++; nfail++;
      $display("FAIL apb_timeout: addr 0x%03h got no PREADY, expected it within 200 cycles", a);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [2:0]  lock;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;
    int          c0;

    vecs[0] = '{12'h018, 32'h0,         1'b0, 3'b000, 32'h0002_0003, 1'b0, 3};
    vecs[1] = '{12'h024, 32'hA5A5_0001, 1'b1, 3'b000, 32'h0002_0003, 1'b0, 3};
    vecs[2] = '{12'h004, 32'h0,         1'b0, 3'b000, 32'h5A5A_0000, 1'b0, 3};
    vecs[3] = '{12'h02C, 32'h0,         1'b0, 3'b000, 32'hC0FF_EE00, 1'b0, 3};
    vecs[4] = '{12'h030, 32'h0,         1'b0, 3'b101, 32'h0000_0005, 1'b0, 0};
    vecs[5] = '{12'h03C, 32'h0,         1'b0, 3'b010, 32'h0000_0002, 1'b0, 0};
    vecs[6] = '{12'hF14, 32'h0,         1'b0, 3'b000, 32'h0002_0003, 1'b0, 3};
    vecs[7] = '{12'h008, 32'h1234_5678, 1'b1, 3'b000, 32'h0002_0003, 1'b0, 3};

    for (int d = 0; d < 3; d++) begin mode[d] = 0; dly[d] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_prdata",  prdata, 32'h0);
    check("rst_pready",  {31'b0, pready}, 32'h0);
    check("rst_pslverr", {31'b0, pslverr}, 32'h0);
    check("rst_req",     {29'b0, req}, 32'h0);
    check("rst_wrn_add", {23'b0, wrn, add[0], add[1], add[2]}, 32'h0);
    check("rst_cdata",   cdata[0] | cdata[1] | cdata[2], 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      lock = vecs[i].lock;
      apb(vecs[i].addr, vecs[i].wdata, vecs[i].wr, rd, err, waits);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_waits", i), waits, vecs[i].exp_waits);
    end
    lock = 3'b000;

    // Cluster write: one req cycle carrying the latched add/data/wrn, other domains quiet
    c0 = mon_clu_cnt;
    apb(12'h024, 32'hA5A5_0001, 1'b1, rd, err, waits);
    check("clu_wr_reqcycles", mon_clu_cnt - c0, 1);
    check("clu_wr_add",  {30'b0, mon_clu_add}, 32'h1);
    check("clu_wr_wrn",  {31'b0, mon_clu_wrn}, 32'h1);
    check("clu_wr_data", mon_clu_data, 32'hA5A5_0001);
    check("clu_wr_others", mon_bad, 0);
    check("clu_wr_err",  {31'b0, err}, 32'h0);

    // soc ack stuck 0: REQ timeout
    mode[0] = 1;
    apb(12'h000, 32'h0, 1'b0, rd, err, waits);
    check("tmo_req_waits", waits, TMO + 1);
    check("tmo_req_err",   {31'b0, err}, 32'h1);
    check("tmo_req_rdata", rd, 32'hDEAD_C1C0);
    apb(12'h030, 32'h0, 1'b0, rd, err, waits);
    check("tmo_req_status", rd, 32'h0000_0010);

    // soc ack stuck 1 after first req: RELEASE timeout
    mode[0] = 2;
    apb(12'h000, 32'h0, 1'b0, rd, err, waits);
    check("tmo_rel_waits", waits, TMO + 1);
    check("tmo_rel_err",   {31'b0, err}, 32'h1);
    check("tmo_rel_rdata", rd, 32'hDEAD_C1C0);

    // soc ack still high while per is accessed: must be ignored
    apb(12'h010, 32'h0, 1'b0, rd, err, waits);
    check("other_ack_waits", waits, 3);
    check("other_ack_rdata", rd, 32'h0002_0003);
    check("other_ack_err",   {31'b0, err}, 32'h0);
    mode[0] = 0;

    // W1C of soc sticky flag
    apb(12'h030, 32'h0000_0010, 1'b1, rd, err, waits);
    check("w1c_waits", waits, 0);
    check("w1c_err",   {31'b0, err}, 32'h0);
    apb(12'h030, 32'h0, 1'b0, rd, err, waits);
    check("w1c_status", rd, 32'h0);

    // per ack delayed 5 cycles
    dly[1] = 5;
    apb(12'h014, 32'h0, 1'b0, rd, err, waits);
    check("dly5_waits", waits, 8);
    check("dly5_err",   {31'b0, err}, 32'h0);
    check("dly5_rdata", rd, 32'h0002_0003);
    dly[1] = 0;
    apb(12'h030, 32'h0, 1'b0, rd, err, waits);
    check("dly5_status", rd, 32'h0);

    // Async reset while in REQ
    mode[0] = 1;
    @(posedge clk); #1;
    paddr = 12'h000; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_req_before", {31'b0, req[0]}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_req_after", {31'b0, req[0]}, 32'h0);
    check("rst_mid_pready",    {31'b0, pready}, 32'h0);
    psel = 1'b0; penable = 1'b0; mode[0] = 0;
    @(negedge clk);
    check("rst_mid_prdata", prdata, 32'h0);
    rstn = 1'b1;
    apb(12'h000, 32'h0, 1'b0, rd, err, waits);
    check("post_rst_waits", waits, 3);
    check("post_rst_rdata", rd, 32'h5A5A_0000);
    check("post_rst_err",   {31'b0, err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
